// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, state encoding and round constant table
package aes_pkg;

   localparam int BLOCK_W = 128;
   localparam int WORD_W  = 32;

   typedef enum logic {IDLE, RUN} state_t;

   // Rcon[r] for r = 1..10; any other index yields zero.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] c;
      case (r)
         4'd1:    c = 8'h01;
         4'd2:    c = 8'h02;
         4'd3:    c = 8'h04;
         4'd4:    c = 8'h08;
         4'd5:    c = 8'h10;
         4'd6:    c = 8'h20;
         4'd7:    c = 8'h40;
         4'd8:    c = 8'h80;
         4'd9:    c = 8'h1b;
         4'd10:   c = 8'h36;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box, shared by key expansion and SubBytes
module aes_sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign dout = SBOX[din];

endmodule

// File: rtl/key_expansion.sv
// rtl/key_expansion.sv - AES-128 on-the-fly key schedule, one round key per enabled cycle
module key_expansion
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               start,
   input  logic [BLOCK_W-1:0] key_i,
   output logic [BLOCK_W-1:0] round_key_o,
   output logic [3:0]         round_idx_o,
   output logic               rk_valid_o,
   output logic               busy_o,
   output logic               done_o
);

   state_t            state;
   logic [WORD_W-1:0] w0, w1, w2, w3;
   logic [WORD_W-1:0] rot, sub, t;
   logic [WORD_W-1:0] n0, n1, n2, n3;
   logic [3:0]        next_idx;
   logic              last_key;

   assign {w0, w1, w2, w3} = round_key_o;
   assign rot      = {w3[23:0], w3[31:24]};
   assign next_idx = round_idx_o + 4'd1;
   assign last_key = (round_idx_o == 4'(NUM_ROUNDS));

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
         .din  (rot[8*g +: 8]),
         .dout (sub[8*g +: 8])
      );
   end

   assign t  = sub ^ {rcon(next_idx), 24'h0};
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   // The done cycle is still spent in RUN so a start seen alongside done is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         round_key_o <= '0;
         round_idx_o <= 4'd0;
         rk_valid_o  <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else if (!en) begin
         rk_valid_o <= 1'b0;
         done_o     <= 1'b0;
      end else begin
         rk_valid_o <= 1'b0;
         done_o     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= RUN;
                  round_key_o <= key_i;
                  round_idx_o <= 4'd0;
                  rk_valid_o  <= 1'b1;
                  busy_o      <= 1'b1;
               end
            end
            RUN: begin
               if (last_key) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else begin
                  round_key_o <= {n0, n1, n2, n3};
                  round_idx_o <= next_idx;
                  rk_valid_o  <= 1'b1;
                  done_o      <= (next_idx == 4'(NUM_ROUNDS));
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_expansion.sv
// tb/tb_key_expansion.sv - randomized and directed self-checking bench for key_expansion
module tb_key_expansion;

   typedef logic [127:0] rk_arr_t [0:10];

   localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] K1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] K0_R1   = 128'h62636363626363636263636362636363;
   localparam logic [127:0] K0_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         start = 1'b0;
   logic [127:0] key_i = '0;
   logic [127:0] round_key_o;
   logic [3:0]   round_idx_o;
   logic         rk_valid_o, busy_o, done_o;

   int checks = 0;
   int errors = 0;

   key_expansion #(.NUM_ROUNDS(10)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .start       (start),
      .key_i       (key_i),
      .round_key_o (round_key_o),
      .round_idx_o (round_idx_o),
      .rk_valid_o  (rk_valid_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk = ~clk;

   // Reference key schedule built from GF(2^8) arithmetic rather than a lookup table.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xtime(x);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_ref(input logic [7:0] a);
      logic [7:0] b = 8'h00;
      if (a != 8'h00) begin
         b = 8'h01;
         for (int i = 0; i < 254; i++) b = gmul(b, a);
      end
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic void expand(input logic [127:0] key, output rk_arr_t ks);
      logic [31:0] w [0:43];
      logic [31:0] tmp;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_ref(tmp[31:24]), sbox_ref(tmp[23:16]), sbox_ref(tmp[15:8]), sbox_ref(tmp[7:0])};
            tmp = tmp ^ {rc, 24'h0};
            rc  = xtime(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r <= 10; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   // Expected outputs, advanced once per clock edge from the accepted key's schedule.
   logic [127:0] exp_key = '0;
   logic [3:0]   exp_idx = 4'd0;
   logic         exp_valid = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
   bit           m_run = 1'b0;
   int           m_k = 0;
   rk_arr_t      m_ks;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_key = '0; exp_idx = 4'd0;
         exp_valid = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
         m_run = 1'b0; m_k = 0;
      end else begin
         exp_valid = 1'b0;
         exp_done  = 1'b0;
         if (en) begin
            if (!m_run) begin
               if (start) begin
                  expand(key_i, m_ks);
                  m_run = 1'b1; m_k = 0;
                  exp_key = m_ks[0]; exp_idx = 4'd0;
                  exp_valid = 1'b1; exp_busy = 1'b1;
               end
            end else if (m_k < 10) begin
               m_k = m_k + 1;
               exp_key = m_ks[m_k]; exp_idx = 4'(m_k);
               exp_valid = 1'b1; exp_done = (m_k == 10);
            end else begin
               m_run = 1'b0; exp_busy = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      checks++;
      if ({round_key_o, round_idx_o, rk_valid_o, busy_o, done_o} !==
          {exp_key, exp_idx, exp_valid, exp_busy, exp_done}) begin
         errors++;
         $display("FAIL cycle t=%0t got key=%h idx=%0d v=%b b=%b d=%b required key=%h idx=%0d v=%b b=%b d=%b",
                  $time, round_key_o, round_idx_o, rk_valid_o, busy_o, done_o,
                  exp_key, exp_idx, exp_valid, exp_busy, exp_done);
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   rk_arr_t pin;

   initial begin
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      chk("reset_key", round_key_o, '0);
      chk("reset_idx", 128'(round_idx_o), 0);
      chk("reset_flags", {125'b0, rk_valid_o, busy_o, done_o}, 0);

      chk("model_sbox_00", 128'(sbox_ref(8'h00)), 128'h63);
      chk("model_sbox_53", 128'(sbox_ref(8'h53)), 128'hed);
      expand(K1, pin);
      chk("model_k1_r1", pin[1], K1_R1);
      chk("model_k1_r10", pin[10], K1_R10);
      expand('0, pin);
      chk("model_k0_r1", pin[1], K0_R1);
      chk("model_k0_r10", pin[10], K0_R10);

      // Known-answer run, plus a start on the done cycle.
      en = 1'b1; key_i = K1; start = 1'b1;
      tick(); start = 1'b0;
      chk("k1_idx0", round_key_o, K1);
      chk("k1_idx0_valid", {round_idx_o, rk_valid_o, busy_o}, {4'd0, 1'b1, 1'b1});
      tick();
      chk("k1_idx1", round_key_o, K1_R1);
      repeat (9) tick();
      chk("k1_idx10", round_key_o, K1_R10);
      chk("k1_done", {round_idx_o, done_o, busy_o}, {4'd10, 1'b1, 1'b1});
      key_i = {$urandom, $urandom, $urandom, $urandom}; start = 1'b1;
      tick(); start = 1'b0;
      chk("done_start_ignored", {rk_valid_o, busy_o, done_o}, 3'b000);
      tick();
      chk("idle_after_done", {rk_valid_o, busy_o}, 2'b00);

      key_i = '0; start = 1'b1;
      tick(); start = 1'b0;
      tick();
      chk("k0_idx1", round_key_o, K0_R1);
      repeat (9) tick();
      chk("k0_idx10", round_key_o, K0_R10);
      tick();

      // Three-cycle enable gap after round key 4.
      expand(K1, pin);
      key_i = K1; start = 1'b1;
      tick(); start = 1'b0;
      repeat (4) tick();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("gap_frozen_key", round_key_o, pin[4]);
         chk("gap_flags", {round_idx_o, rk_valid_o, done_o}, {4'd4, 1'b0, 1'b0});
      end
      en = 1'b1;
      repeat (5) tick();
      chk("gap_no_early_done", {round_idx_o, done_o}, {4'd9, 1'b0});
      tick();
      chk("gap_idx10", round_key_o, K1_R10);
      chk("gap_done", 128'(done_o), 1);
      tick();

      // Start in mid-run must not restart.
      key_i = K1; start = 1'b1;
      tick(); start = 1'b0;
      repeat (5) tick();
      key_i = {$urandom, $urandom, $urandom, $urandom}; start = 1'b1;
      tick(); start = 1'b0;
      chk("midstart_idx6", round_key_o, pin[6]);
      repeat (4) tick();
      chk("midstart_idx10", round_key_o, K1_R10);
      tick();

      // Asynchronous abort at round key 6.
      key_i = K1; start = 1'b1;
      tick(); start = 1'b0;
      repeat (6) tick();
      #1 rst = 1'b1;
      #1;
      chk("abort_key", round_key_o, '0);
      chk("abort_flags", {round_idx_o, rk_valid_o, busy_o, done_o}, 7'd0);
      tick(); rst = 1'b0;
      key_i = {$urandom, $urandom, $urandom, $urandom}; start = 1'b1;
      pin[0] = key_i;
      tick(); start = 1'b0;
      chk("post_reset_idx0", round_key_o, pin[0]);
      chk("post_reset_flags", {round_idx_o, rk_valid_o, busy_o}, {4'd0, 1'b1, 1'b1});
      repeat (11) tick();

      for (int i = 0; i < 400; i++) begin
         en    = ($urandom_range(0, 3) != 0);
         start = ($urandom_range(0, 4) == 0);
         key_i = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end
      en = 1'b1; start = 1'b0;
      repeat (15) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
